// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract unit: adds DATA_WIDTH-bit operands CHUNK_WIDTH bits per clock,
// LSB chunk first, with a rippled carry, start/ready/valid handshake and carry/overflow flags.
module chunked_serial_adder #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start_In,
    input  logic                  Sub_Mode_In,
    input  logic                  Carry_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    output logic                  Ready_Out,
    output logic                  Valid_Out,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out,
    output logic                  Overflow_Out
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [DATA_WIDTH-1:0]   acc;
    logic                    carry;

    logic [CHUNK_WIDTH-1:0]  a_chunk;
    logic [CHUNK_WIDTH-1:0]  b_chunk;
    logic [CHUNK_WIDTH:0]    chunk_sum;
    logic [DATA_WIDTH-1:0]   sum_next;

    // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
    function automatic logic overflow_flag(input logic a_msb, input logic b_msb,
                                           input logic s_msb, input logic c_out);
        return (a_msb ^ b_msb ^ s_msb) ^ c_out;
    endfunction

    always_comb begin
        a_chunk   = a_reg[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk   = b_reg[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry};
        sum_next  = acc;
        sum_next[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            Ready_Out    <= 1'b1;
            Valid_Out    <= 1'b0;
            Sum_Out      <= '0;
            Carry_Out    <= 1'b0;
            Overflow_Out <= 1'b0;
        end else begin
            Valid_Out <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start_In) begin
                        // Subtraction is A + ~B + 1, so the add path is shared.
                        a_reg     <= Data_A_In;
                        b_reg     <= Sub_Mode_In ? ~Data_B_In : Data_B_In;
                        carry     <= Sub_Mode_In ? 1'b1 : Carry_In;
                        cnt       <= '0;
                        state     <= RUN;
                        Ready_Out <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= sum_next;
                    carry <= chunk_sum[CHUNK_WIDTH];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CHUNK) begin
                        Sum_Out      <= sum_next;
                        Carry_Out    <= chunk_sum[CHUNK_WIDTH];
                        Overflow_Out <= overflow_flag(a_reg[DATA_WIDTH-1], b_reg[DATA_WIDTH-1],
                                                      sum_next[DATA_WIDTH-1],
                                                      chunk_sum[CHUNK_WIDTH]);
                        Valid_Out    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    Ready_Out <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    Ready_Out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (chunk widths 4, 16, 1) checked against a
// queue-based scoreboard of {carry, overflow, sum} computed from a reference add model.
module tb_chunked_serial_adder;

    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Sub;
    logic          Cin;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [2:0]    start;

    logic [2:0]    rdy;
    logic [2:0]    vld;
    logic [2:0]    co;
    logic [2:0]    ov;
    logic [DW-1:0] sum0;
    logic [DW-1:0] sum1;
    logic [DW-1:0] sum2;

    int total = 0;
    int bad   = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] q2[$];
    logic [17:0] e0;
    logic [17:0] e1;
    logic [17:0] e2;
    int          acc_idx[$];

    always #5 Clk = ~Clk;

    chunked_serial_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .Start_In(start[0]), .Sub_Mode_In(Sub), .Carry_In(Cin),
        .Data_A_In(A), .Data_B_In(B), .Ready_Out(rdy[0]), .Valid_Out(vld[0]),
        .Sum_Out(sum0), .Carry_Out(co[0]), .Overflow_Out(ov[0]));

    chunked_serial_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(16)) dut16 (
        .Clk(Clk), .Reset_n(Reset_n), .Start_In(start[1]), .Sub_Mode_In(Sub), .Carry_In(Cin),
        .Data_A_In(A), .Data_B_In(B), .Ready_Out(rdy[1]), .Valid_Out(vld[1]),
        .Sum_Out(sum1), .Carry_Out(co[1]), .Overflow_Out(ov[1]));

    chunked_serial_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Start_In(start[2]), .Sub_Mode_In(Sub), .Carry_In(Cin),
        .Data_A_In(A), .Data_B_In(B), .Ready_Out(rdy[2]), .Valid_Out(vld[2]),
        .Sum_Out(sum2), .Carry_Out(co[2]), .Overflow_Out(ov[2]));

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
        logic [15:0] bb;
        logic [16:0] r;
        logic        v;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        v  = (a[15] == bb[15]) && (r[15] != a[15]);
        return {r[16], v, r[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop side: one result per Valid_Out pulse, per instance.
    always @(negedge Clk) begin
        if (vld[0] === 1'b1) begin
            if (q0.size() == 0) check("dut4 unexpected valid", 32'd1, 32'd0);
            else begin
                e0 = q0.pop_front();
                check("dut4 result", 32'({co[0], ov[0], sum0}), 32'(e0));
            end
        end
        if (vld[1] === 1'b1) begin
            if (q1.size() == 0) check("dut16 unexpected valid", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("dut16 result", 32'({co[1], ov[1], sum1}), 32'(e1));
            end
        end
        if (vld[2] === 1'b1) begin
            if (q2.size() == 0) check("dut1 unexpected valid", 32'd1, 32'd0);
            else begin
                e2 = q2.pop_front();
                check("dut1 result", 32'({co[2], ov[2], sum2}), 32'(e2));
            end
        end
    end

    // Called and returns at a falling edge; start is seen by the DUTs on the next rising edge.
    task automatic issue(input logic [2:0] mask, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin, input bit push);
        int n;
        logic [17:0] e;
        n = 0;
        while (((rdy & mask) != mask) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) begin
            check("issue ready timeout", 32'd0, 32'd1);
            return;
        end
        A = a; B = b; Sub = sub; Cin = cin;
        start = mask;
        if (push) begin
            e = model(a, b, sub, cin);
            if (mask[0]) q0.push_back(e);
            if (mask[1]) q1.push_back(e);
            if (mask[2]) q2.push_back(e);
        end
        @(negedge Clk);
        start = 3'b000;
        A = 16'($urandom); B = 16'($urandom);
        Sub = 1'($urandom); Cin = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && rdy == 3'b111) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check("drain within budget", 32'(n < 400), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n = 1'b0;
        start   = 3'b000;
        A = '0; B = '0; Sub = 1'b0; Cin = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset state
        check("reset ready", 32'(rdy), 32'h7);
        check("reset valid", 32'(vld), 32'h0);
        check("reset sums", 32'({sum0, sum1 | sum2}), 32'h0);
        check("reset flags", 32'({co, ov}), 32'h0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Test 1: latency and ready timing on the 4-bit-chunk instance
        issue(3'b001, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1 ready after edge %0d", i), 32'(rdy[0]), 32'(i == 5));
            check($sformatf("t1 valid after edge %0d", i), 32'(vld[0]), 32'(i == 4));
            @(negedge Clk);
        end
        wait_drain();

        // Tests 2 and 3: carry, overflow and borrow boundaries on all three instances
        issue(3'b111, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue(3'b111, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1);
        issue(3'b111, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        issue(3'b111, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
        issue(3'b111, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1);
        issue(3'b111, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        wait_drain();
        check("t2 last sum4", 32'(sum0), 32'hFFFF);
        check("t2 last carry4", 32'(co[0]), 32'd1);

        // Test 4: Start held high for 20 cycles with changing operands
        acc_idx.delete();
        for (int c = 0; c < 20; c++) begin
            A = 16'($urandom); B = 16'($urandom);
            Sub = 1'($urandom); Cin = 1'($urandom);
            start = 3'b001;
            if (rdy[0] === 1'b1) begin
                q0.push_back(model(A, B, Sub, Cin));
                acc_idx.push_back(c);
            end
            @(negedge Clk);
        end
        start = 3'b000;
        check("t4 accept count", 32'(acc_idx.size()), 32'd4);
        for (int k = 0; k < acc_idx.size(); k++)
            check($sformatf("t4 accept %0d cycle", k), 32'(acc_idx[k]), 32'(6 * k));
        wait_drain();

        // Test 5: reset during RUN chunk 2 aborts with no result
        issue(3'b001, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        check("t5 ready after reset", 32'(rdy[0]), 32'd1);
        check("t5 valid after reset", 32'(vld[0]), 32'd0);
        check("t5 outputs after reset", 32'({co[0], ov[0], sum0}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            check($sformatf("t5 no valid cycle %0d", i), 32'(vld[0]), 32'd0);
        end
        issue(3'b001, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check("t5 recovered sum", 32'(sum0), 32'h5555);

        // Test 6: random operations on all chunk widths
        for (int i = 0; i < 1000; i++)
            issue(3'b111, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
